// File: rtl/buzzer_tone_driver.sv
// buzzer_tone_driver: debounces a one-hot 21-note request (three octaves of
// do..si) and drives a piezo buzzer with the matching square wave. A silent
// articulation gap separates two different notes. A request with several bits
// set is flagged on note_err and keeps the buzzer quiet.
module buzzer_tone_driver #(
  parameter int CLK_FREQ      = 100000000,
  parameter int STABLE_CYCLES = 100000,
  parameter int GAP_CYCLES    = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] note_in,
  output logic        buzzer,
  output logic [4:0]  note_idx,
  output logic        playing,
  output logic        note_err
);

  // Half-period in clk cycles for note k, rounded to nearest. The base
  // frequencies are held in centi-Hz so the whole computation stays integer.
  function automatic int half_for(input int k);
    longint f_centi;
    longint num;
    longint den;
    case (3'(k % 7))
      3'd0:    f_centi = 64'd26163;
      3'd1:    f_centi = 64'd29366;
      3'd2:    f_centi = 64'd32963;
      3'd3:    f_centi = 64'd34923;
      3'd4:    f_centi = 64'd39200;
      3'd5:    f_centi = 64'd44000;
      3'd6:    f_centi = 64'd49388;
      default: f_centi = 64'd49388;
    endcase
    den = 64'd2 * f_centi * (64'd1 << (k / 7));
    num = longint'(CLK_FREQ) * 64'd100;
    return int'((num + den / 64'd2) / den);
  endfunction

  // Index of the set bit of a one-hot value; 31 when no bit is set.
  function automatic logic [4:0] onehot_idx(input logic [20:0] v);
    logic [4:0] idx;
    idx = 5'd31;
    for (int i = 0; i < 21; i++) begin
      if (v[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  // True when two or more bits are set.
  function automatic logic is_multi(input logic [20:0] v);
    return (v & (v - 21'd1)) != 21'd0;
  endfunction

  // The lowest note (low do) has the longest half-period and sets the width.
  localparam int HALF_MAX = half_for(0);
  localparam int TW = (HALF_MAX < 2) ? 1 : $clog2(HALF_MAX + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Half-period minus one for every note, fixed at elaboration.
  logic [TW-1:0] half_m1 [21];
  for (genvar g = 0; g < 21; g++) begin : g_half
    localparam logic [TW-1:0] HM1 = TW'(half_for(g) - 1);
    assign half_m1[g] = HM1;
  end

  logic [20:0]   sample_r;
  logic [SW-1:0] stab_cnt_r;
  logic          acc_pulse_r;
  logic [20:0]   acc_note_r;

  state_t        state_r;
  logic [4:0]    cur_k_r;
  logic [4:0]    pend_k_r;
  logic [TW-1:0] half_r;
  logic [TW-1:0] tone_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic          buzzer_r;
  logic          playing_r;
  logic [4:0]    idx_r;
  logic          err_r;

  logic          acc_silent_s;
  logic          acc_multi_s;
  logic          acc_one_s;
  logic [4:0]    acc_k_s;
  logic [4:0]    gap_k_s;
  logic [4:0]    play_k_s;
  logic [TW-1:0] play_half_s;

  // Input filter: register the request and count consecutive equal samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r   <= 21'd0;
      stab_cnt_r <= '0;
    end else begin
      sample_r <= note_in;
      if (note_in != sample_r) begin
        stab_cnt_r <= '0;
      end else if (stab_cnt_r != SW'(STABLE_CYCLES)) begin
        stab_cnt_r <= stab_cnt_r + SW'(1);
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  // Acceptance: one pulse per stable run, latching the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_pulse_r <= 1'b0;
      acc_note_r  <= 21'd0;
    end else begin
      if (stab_cnt_r == SW'(STABLE_CYCLES - 1)) begin
        acc_pulse_r <= 1'b1;
        acc_note_r  <= sample_r;
      end else begin
        acc_pulse_r <= 1'b0;
        acc_note_r  <= acc_note_r;
      end
    end
  end

  // Classify the accepted request and pick the note a PLAY entry would use.
  always_comb begin
    acc_silent_s = 1'b0;
    acc_multi_s  = 1'b0;
    acc_one_s    = 1'b0;
    acc_k_s      = onehot_idx(acc_note_r);
    if (acc_pulse_r) begin
      if (acc_note_r == 21'd0) begin
        acc_silent_s = 1'b1;
      end else if (is_multi(acc_note_r)) begin
        acc_multi_s = 1'b1;
      end else begin
        acc_one_s = 1'b1;
      end
    end else begin
      acc_silent_s = 1'b0;
    end
    gap_k_s  = acc_one_s ? acc_k_s : pend_k_r;
    play_k_s = (state_r == GAP) ? gap_k_s : acc_k_s;
    if (play_k_s <= 5'd20) begin
      play_half_s = half_m1[play_k_s];
    end else begin
      play_half_s = '0;
    end
  end

  // Tone FSM with registered outputs; an accepted request always wins over
  // the gap timer expiring in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cur_k_r    <= 5'd31;
      pend_k_r   <= 5'd0;
      half_r     <= '0;
      tone_cnt_r <= '0;
      gap_cnt_r  <= '0;
      buzzer_r   <= 1'b0;
      playing_r  <= 1'b0;
      idx_r      <= 5'd31;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, ERR, GAP, PLAY: begin
          if (acc_silent_s) begin
            state_r    <= IDLE;
            tone_cnt_r <= '0;
            buzzer_r   <= 1'b0;
            playing_r  <= 1'b0;
            idx_r      <= 5'd31;
            err_r      <= 1'b0;
          end else if (acc_multi_s) begin
            state_r    <= ERR;
            tone_cnt_r <= '0;
            buzzer_r   <= 1'b0;
            playing_r  <= 1'b0;
            idx_r      <= 5'd31;
            err_r      <= 1'b1;
          end else if (state_r == PLAY) begin
            if (acc_one_s && (acc_k_s != cur_k_r)) begin
              state_r    <= GAP;
              pend_k_r   <= acc_k_s;
              gap_cnt_r  <= '0;
              tone_cnt_r <= '0;
              buzzer_r   <= 1'b0;
              playing_r  <= 1'b0;
              idx_r      <= 5'd31;
            end else if (tone_cnt_r == half_r) begin
              tone_cnt_r <= '0;
              buzzer_r   <= ~buzzer_r;
            end else begin
              tone_cnt_r <= tone_cnt_r + TW'(1);
            end
          end else if ((state_r == GAP) && (gap_cnt_r != GW'(GAP_CYCLES - 1))) begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
            pend_k_r  <= gap_k_s;
          end else if (acc_one_s || (state_r == GAP)) begin
            state_r    <= PLAY;
            cur_k_r    <= play_k_s;
            half_r     <= play_half_s;
            tone_cnt_r <= '0;
            buzzer_r   <= 1'b0;
            playing_r  <= 1'b1;
            idx_r      <= play_k_s;
            err_r      <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          buzzer_r <= 1'b0;
          playing_r <= 1'b0;
          idx_r    <= 5'd31;
          err_r    <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer   = buzzer_r;
  assign note_idx = idx_r;
  assign playing  = playing_r;
  assign note_err = err_r;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Bench for buzzer_tone_driver: a behavioural model (run-length filter,
// mode + start-time tone formula) checked every cycle, plus directed
// literal checks of the key timings.
module tb_buzzer_tone_driver;
  localparam int CLK_FREQ = 1000000;
  localparam int S        = 4;
  localparam int GAPC     = 8;

  localparam int M_IDLE = 0;
  localparam int M_GAP  = 1;
  localparam int M_PLAY = 2;
  localparam int M_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] note_in = 21'd0;
  logic        buzzer;
  logic [4:0]  note_idx;
  logic        playing;
  logic        note_err;

  int total = 0;
  int bad   = 0;

  buzzer_tone_driver #(
    .CLK_FREQ(CLK_FREQ),
    .STABLE_CYCLES(S),
    .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .note_in(note_in),
    .buzzer(buzzer),
    .note_idx(note_idx),
    .playing(playing),
    .note_err(note_err)
  );

  always #5 clk = ~clk;

  real base_hz [7] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88};

  function automatic int half_of(input int k);
    real f;
    f = base_hz[k % 7] * (2.0 ** (k / 7));
    return $rtoi(real'(CLK_FREQ) / (2.0 * f) + 0.5);
  endfunction

  // ---------------- behavioural model ----------------
  // The filter accepts a value when its run of identical samples reaches S;
  // the tone FSM reacts to that acceptance two clocks later.
  int          n = 0;
  int          m_mode = M_IDLE;
  int          m_k = 0;
  int          m_start = 0;
  int          m_gap_end = 0;
  int          m_pend = 0;
  logic [20:0] f_last = 21'd0;
  int          f_run = 1;
  bit          h1_v = 1'b0;
  bit          h2_v = 1'b0;
  logic [20:0] h1_n = 21'd0;
  logic [20:0] h2_n = 21'd0;
  int          cls;
  int          j;
  logic        e_buz;
  logic        e_play;
  logic        e_err;
  logic [4:0]  e_idx;

  task automatic go_play(input int k);
    m_mode  = M_PLAY;
    m_k     = k;
    m_start = n;
  endtask

  always @(negedge clk) begin
    n++;
    if (rst) begin
      m_mode = M_IDLE;
      f_last = 21'd0;
      f_run  = 1;
      h1_v   = 1'b0;
      h2_v   = 1'b0;
    end else begin
      if (!h2_v) cls = -1;
      else if (h2_n == 21'd0) cls = 0;
      else if ($countones(h2_n) == 1) cls = 1;
      else cls = 2;
      j = 31;
      for (int b = 0; b < 21; b++) if (h2_n[b]) j = b;
      case (m_mode)
        M_IDLE: begin
          if (cls == 1) go_play(j);
          else if (cls == 2) m_mode = M_ERR;
        end
        M_ERR: begin
          if (cls == 0) m_mode = M_IDLE;
          else if (cls == 1) go_play(j);
        end
        M_PLAY: begin
          if (cls == 0) m_mode = M_IDLE;
          else if (cls == 2) m_mode = M_ERR;
          else if (cls == 1 && j != m_k) begin
            m_mode = M_GAP;
            m_pend = j;
            m_gap_end = n + GAPC;
          end
        end
        default: begin
          if (cls == 0) m_mode = M_IDLE;
          else if (cls == 2) m_mode = M_ERR;
          else begin
            if (cls == 1) m_pend = j;
            if (n == m_gap_end) go_play(m_pend);
          end
        end
      endcase
      if (note_in == f_last) f_run++;
      else begin
        f_run  = 1;
        f_last = note_in;
      end
      h2_v = h1_v;
      h2_n = h1_n;
      h1_v = (f_run == S);
      h1_n = note_in;
    end
    e_play = (m_mode == M_PLAY);
    e_err  = (m_mode == M_ERR);
    e_idx  = e_play ? 5'(m_k) : 5'd31;
    e_buz  = e_play ? 1'(((n - m_start) / half_of(m_k)) % 2) : 1'b0;
    total++;
    if ({buzzer, playing, note_err, note_idx} !== {e_buz, e_play, e_err, e_idx}) begin
      bad++;
      $display("FAIL model cyc=%0d: got buz=%b play=%b err=%b idx=%0d, want buz=%b play=%b err=%b idx=%0d",
               n, buzzer, playing, note_err, note_idx, e_buz, e_play, e_err, e_idx);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_idx", 32'(note_idx), 32'd31);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_err", 32'(note_err), 32'd0);
    chk("half_la", 32'(half_of(5)), 32'd1136);
    chk("half_la_mid", 32'(half_of(12)), 32'd568);
    rst = 1'b0;

    // low la: silent until the filter accepts, then 1136-cycle half-periods
    note_in = 21'h000020;
    cyc(5);  chk("la_not_yet", 32'(playing), 32'd0);
    cyc(1);  chk("la_playing", 32'(playing), 32'd1);
    chk("la_idx", 32'(note_idx), 32'd5);
    chk("la_buz_start", 32'(buzzer), 32'd0);
    cyc(1135); chk("la_before_t1", 32'(buzzer), 32'd0);
    cyc(1);    chk("la_t1", 32'(buzzer), 32'd1);
    cyc(1135); chk("la_before_t2", 32'(buzzer), 32'd1);
    cyc(1);    chk("la_t2", 32'(buzzer), 32'd0);

    // 3-cycle glitch must not disturb the tone phase
    note_in = 21'h000001;
    cyc(3);
    note_in = 21'h000020;
    cyc(10); chk("glitch_idx", 32'(note_idx), 32'd5);
    cyc(1122); chk("glitch_before_t3", 32'(buzzer), 32'd0);
    cyc(1);    chk("glitch_t3", 32'(buzzer), 32'd1);

    // middle la: 8-cycle gap, then 568-cycle half-periods
    note_in = 21'h001000;
    cyc(5); chk("sw_still_la", 32'(note_idx), 32'd5);
    cyc(1); chk("gap_playing", 32'(playing), 32'd0);
    chk("gap_idx", 32'(note_idx), 32'd31);
    cyc(7); chk("gap_end_playing", 32'(playing), 32'd0);
    chk("gap_end_buz", 32'(buzzer), 32'd0);
    cyc(1); chk("mid_la_idx", 32'(note_idx), 32'd12);
    chk("mid_la_playing", 32'(playing), 32'd1);
    cyc(567); chk("mid_before_t1", 32'(buzzer), 32'd0);
    cyc(1);   chk("mid_t1", 32'(buzzer), 32'd1);

    // two bits set: error, quiet; then silence clears it
    note_in = 21'h000003;
    cyc(6); chk("err_flag", 32'(note_err), 32'd1);
    chk("err_buz", 32'(buzzer), 32'd0);
    chk("err_idx", 32'(note_idx), 32'd31);
    cyc(1200); chk("err_still_quiet", 32'(buzzer), 32'd0);
    note_in = 21'd0;
    cyc(6); chk("err_clear", 32'(note_err), 32'd0);
    chk("err_clear_idx", 32'(note_idx), 32'd31);

    // different note during the gap replaces the pending note
    note_in = 21'h000020; cyc(8);
    note_in = 21'h001000; cyc(5);
    note_in = 21'h000001;
    cyc(8); chk("repl_gap", 32'(playing), 32'd0);
    cyc(1); chk("repl_idx", 32'(note_idx), 32'd0);

    // silence during the gap, then invalid during the gap
    note_in = 21'h000020; cyc(20);
    note_in = 21'h001000; cyc(5);
    note_in = 21'd0; cyc(10);
    chk("gap_silent_idx", 32'(note_idx), 32'd31);
    note_in = 21'h000020; cyc(20);
    note_in = 21'h001000; cyc(5);
    note_in = 21'h000003; cyc(10);
    chk("gap_invalid_err", 32'(note_err), 32'd1);
    note_in = 21'd0; cyc(10);

    // a short request in IDLE never sounds
    note_in = 21'h000020; cyc(3);
    note_in = 21'd0; cyc(10);
    chk("short_req", 32'(playing), 32'd0);

    // reset while the buzzer is high silences it at once
    note_in = 21'h000020; cyc(20);
    for (int i = 0; i < 1200 && buzzer !== 1'b1; i++) cyc(1);
    chk("pre_rst_buz_high", 32'(buzzer), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_buz", 32'(buzzer), 32'd0);
    chk("rst_async_playing", 32'(playing), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(5); chk("post_rst_wait", 32'(playing), 32'd0);
    cyc(1); chk("post_rst_play", 32'(playing), 32'd1);
    chk("post_rst_idx", 32'(note_idx), 32'd5);

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buzzer_tone_driver.md
BUZZER_TONE_DRIVER -- requirements
Module: buzzer_tone_driver

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, is the clk frequency in Hz.
REQ-002 Parameter STABLE_CYCLES, default 100000, is the number of consecutive identical samples of note_in required before the note is accepted.
REQ-003 Parameter GAP_CYCLES, default 2000000, is the silent articulation gap inserted between two different accepted notes.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 note_in  input  21  one-hot note request: bit k = octave*7 + degree; degree 0..6 = do..si; octave 0/1/2 = low/middle/high; all-zero = silence.
REQ-007 buzzer  output  1  square-wave drive to the piezo buzzer.
REQ-008 note_idx  output  5  index 0..20 of the note being sounded; 31 when silent.
REQ-009 playing  output  1  high while buzzer is toggling.
REQ-010 note_err  output  1  high while the accepted input has more than one bit set.

Function
REQ-011 Base frequencies, octave 0, shall be: do 261.63, re 293.66, mi 329.63, fa 349.23, so 392.00, la 440.00, si 493.88 Hz; octave 1 ×2; octave 2 ×4.
REQ-012 Half-period count for note k shall be round(CLK_FREQ / (2·f_k)), computed at elaboration; counter width is 18 bits minimum at the default CLK_FREQ.
REQ-013 Filter: note_in is registered every cycle; a stability counter resets on any change and increments otherwise; after STABLE_CYCLES equal samples the value becomes the accepted note.
REQ-014 Accepted value classes: zero = SILENT; exactly one bit set = VALID(k); two or more bits set = INVALID.
REQ-015 FSM states shall be IDLE, GAP, PLAY, ERR.
REQ-016 IDLE: buzzer=0, playing=0, note_idx=31; a VALID(k) acceptance moves to PLAY on the next cycle; an INVALID acceptance moves to ERR.
REQ-017 PLAY: the tone counter counts 0..half-1; on reaching half-1 the counter returns to 0 and buzzer toggles; the first toggle occurs half cycles after entering PLAY with buzzer starting at 0.
REQ-018 PLAY with a new VALID(j), j≠k: go to GAP, buzzer=0, counter cleared, note_idx=31, playing=0.
REQ-019 PLAY with a re-acceptance of the same k: no effect; tone phase is continuous.
REQ-020 PLAY with SILENT: go to IDLE; with INVALID: go to ERR.
REQ-021 GAP: lasts exactly GAP_CYCLES cycles, then PLAY with the most recently accepted VALID note; SILENT during GAP goes to IDLE; INVALID goes to ERR; a different VALID note during GAP replaces the pending note without restarting the gap timer.
REQ-022 ERR: buzzer=0, playing=0, note_idx=31, note_err=1; leaves to IDLE on SILENT or to PLAY on VALID; note_err=0 in every other state.
REQ-023 Input changes shorter than STABLE_CYCLES shall never change state or outputs.
REQ-024 Outputs shall be registered; no combinational path from note_in to any output.

Reset
REQ-025 While rst is high: state=IDLE, buzzer=0, playing=0, note_idx=31, note_err=0, all counters=0, accepted note=SILENT.
REQ-026 Reset asserted mid-note or mid-gap shall silence buzzer immediately (asynchronously); after release, a note held steady still requires a full STABLE_CYCLES before it sounds.

Verification (CLK_FREQ=1000000, STABLE_CYCLES=4, GAP_CYCLES=8)
REQ-027 note_in=21'h000020 (la, octave 0) held -> after 4 stable cycles playing=1, note_idx=5; buzzer toggles every 1136 cycles.
REQ-028 la playing, then note_in switches to 21'h001000 (bit 12, middle la) -> 8-cycle gap with buzzer=0, playing=0; then note_idx=12, toggling every 568 cycles.
REQ-029 note_in=21'h000003 held -> note_err=1, buzzer constant 0; then note_in=0 -> note_err=0, note_idx=31.
REQ-030 3-cycle glitch to 21'h000001 during a steady la -> no change in note_idx or tone phase.
REQ-031 rst pulse mid-PLAY -> buzzer=0 within the same cycle; after release with la held, sound resumes only after 4 stable cycles.
